// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: default source count,
// register map and FSM state encoding.
package int_ctrl_pkg;

    localparam int NSRC_DEFAULT = 6;

    // Served id field width; VEC exposes it in bits [2:0].
    localparam int ID_W = 3;

    localparam logic [1:0] ADDR_PEND = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_MODE = 2'd2;
    localparam logic [1:0] ADDR_VEC  = 2'd3;

    localparam int VEC_ACTIVE_BIT = 31;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one interrupt line plus a rising-edge pulse
// that is suppressed until the delayed copy holds a genuinely sampled value.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise
);

    logic       meta_reg;
    logic       sync_reg;
    logic       prev_reg;
    logic [2:0] arm_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
            arm_reg  <= '0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
            arm_reg  <= {arm_reg[1:0], 1'b1};
        end
    end

    // A line already high when reset releases reaches prev_reg on the same
    // edge that arms detection, so it never produces a pulse.
    assign sync = sync_reg;
    assign rise = sync_reg & ~prev_reg & arm_reg[2];

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller between device interrupt lines and the CP0 hardware
// interrupt inputs: pending/mask/mode registers, fixed priority, EOI handshake.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NSRC = NSRC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [NSRC-1:0] hwint
);

    logic [NSRC-1:0] sync_vec;
    logic [NSRC-1:0] rise_vec;
    logic [NSRC-1:0] pend_reg;
    logic [NSRC-1:0] pend_next;
    logic [NSRC-1:0] mask_reg;
    logic [NSRC-1:0] mode_reg;
    logic [NSRC-1:0] hwint_reg;
    logic [NSRC-1:0] clr_vec;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] grant_onehot;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] id_reg;
    state_t          state_reg;
    logic            pend_wr;
    logic            eoi;
    logic            eoi_accept;
    logic            unused_wdata;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_sync
            sync_edge u_sync_edge (
                .clk   (clk),
                .reset (reset),
                .din   (src[gi]),
                .sync  (sync_vec[gi]),
                .rise  (rise_vec[gi])
            );
        end
    endgenerate

    assign pend_wr    = we && (addr == ADDR_PEND);
    assign eoi        = we && (addr == ADDR_VEC);
    assign eoi_accept = eoi && (state_reg == SERVE);

    // In SERVE hwint_reg is the one-hot of the served id, so it doubles as
    // the clear mask for the EOI.
    assign clr_vec = (pend_wr ? wdata[NSRC-1:0] : '0) | (eoi_accept ? hwint_reg : '0);

    // Edge bits: a new edge wins over a simultaneous clear. Level bits simply
    // track the synchronized line and ignore clears.
    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_pend
            assign pend_next[gi] = mode_reg[gi]
                                 ? (rise_vec[gi] | (pend_reg[gi] & ~clr_vec[gi]))
                                 : sync_vec[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_reg <= '0;
            mask_reg <= '0;
            mode_reg <= '0;
        end else begin
            pend_reg <= pend_next;
            if (we && (addr == ADDR_MASK)) begin
                mask_reg <= wdata[NSRC-1:0];
            end
            if (we && (addr == ADDR_MODE)) begin
                mode_reg <= wdata[NSRC-1:0];
            end
        end
    end

    assign req = pend_reg & mask_reg;

    // Scan from the top down so the lowest set index is the one that sticks.
    always_comb begin
        grant_id     = '0;
        grant_onehot = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_id        = ID_W'(i);
                grant_onehot    = '0;
                grant_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            id_reg    <= '0;
            hwint_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        state_reg <= SERVE;
                        id_reg    <= grant_id;
                        hwint_reg <= grant_onehot;
                    end
                end
                SERVE: begin
                    if (eoi_accept) begin
                        state_reg <= IDLE;
                        id_reg    <= '0;
                        hwint_reg <= '0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    id_reg    <= '0;
                    hwint_reg <= '0;
                end
            endcase
        end
    end

    assign hwint = hwint_reg;

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_PEND: rdata[NSRC-1:0] = pend_reg;
            ADDR_MASK: rdata[NSRC-1:0] = mask_reg;
            ADDR_MODE: rdata[NSRC-1:0] = mode_reg;
            ADDR_VEC: begin
                rdata[VEC_ACTIVE_BIT] = (state_reg == SERVE);
                rdata[ID_W-1:0]       = id_reg;
            end
            default: rdata = '0;
        endcase
    end

    // Register fields are NSRC wide; the rest of the write bus is don't-care.
    assign unused_wdata = ^wdata[31:NSRC];

endmodule
